// File: rtl/mdu.sv
// ============================================================================
// Module   : mdu
// Purpose  : Iterative RV32M multiply/divide unit (shift-add / restoring, 1 bit/cycle)
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd
);

    localparam int              c_CW   = $clog2(XLEN);
    localparam logic [0:0]      c_IDLE = 1'b0;
    localparam logic [0:0]      c_CALC = 1'b1;
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic              r_done;
    logic [XLEN-1:0]   r_rd;

    logic              w_sgn_a;
    logic              w_sgn_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    // Operand decode at issue: signedness per op, magnitudes, fast-path detection
    assign w_sgn_a    = rs1[XLEN-1] & (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
    assign w_sgn_b    = rs2[XLEN-1] & (funct3 inside {3'd1, 3'd4, 3'd6});
    assign w_mag_a    = w_sgn_a ? (~rs1 + 1'b1) : rs1;
    assign w_mag_b    = w_sgn_b ? (~rs2 + 1'b1) : rs2;
    assign w_div0     = funct3[2] && (rs2 == '0);
    assign w_ovf      = (funct3 == 3'd4 || funct3 == 3'd6) && (rs1 == c_MIN) && (rs2 == '1);
    assign w_fast     = w_div0 | w_ovf;
    assign w_fast_res = w_div0 ? (funct3[1] ? rs1 : '1)
                               : (funct3[1] ? '0  : c_MIN);

    // Multiply step adds into the upper half; divide step uses {remainder, quotient}
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_trial   = w_rem_sh - {1'b0, r_b};
    assign w_acc_nxt = r_op[2]
        ? {(w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0]),
           r_acc[XLEN-2:0], ~w_trial[XLEN]}
        : {w_sum, r_acc[XLEN-1:1]};

    assign w_prod = r_neg     ? (~w_acc_nxt + 1'b1)                    : w_acc_nxt;
    assign w_quo  = r_neg     ? (~w_acc_nxt[XLEN-1:0] + 1'b1)          : w_acc_nxt[XLEN-1:0];
    assign w_rem  = r_neg_rem ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1)     : w_acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        w_result = w_prod[XLEN-1:0];
        case (r_op)
            3'd0:                   w_result = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       w_result = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:             w_result = w_quo;
            default:                w_result = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start && !w_fast) w_state_nxt = c_CALC;
            c_CALC:  if (r_cnt == '0)      w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_rd      <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_IDLE) begin
                if (start) begin
                    r_op      <= funct3;
                    r_neg     <= w_sgn_a ^ w_sgn_b;
                    r_neg_rem <= w_sgn_a;
                    r_b       <= w_mag_b;
                    r_acc     <= {{XLEN{1'b0}}, w_mag_a};
                    r_cnt     <= c_CW'(XLEN-1);
                    if (w_fast) begin
                        r_rd   <= w_fast_res;
                        r_done <= 1'b1;
                    end
                end
            end else begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_rd   <= w_result;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign rd   = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// ============================================================================
// Module   : tb_mdu
// Purpose  : Self-checking bench for mdu: directed table, random vs. model, handshake cases
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] rd;

    int n_pass;
    int n_total;

    mdu #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .rd     (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural RV32M reference using wide arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called at start-edge+1; lat counts edges from the start edge to the edge that sees done
    task automatic wait_done(output int lat, output int bcnt, output logic [31:0] res);
        lat  = 1;
        bcnt = 0;
        res  = 'x;
        forever begin
            if (done) begin
                res = rd;
                break;
            end
            if (busy) bcnt++;
            if (lat >= 100) begin
                n_total++;
                $display("FAIL timeout: no done after %0d edges, required done", lat);
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          bcnt;
        int          dcnt;
        logic [31:0] res;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        n_pass  = 0;
        n_total = 0;
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

        start  = 1'b0;
        funct3 = 3'd0;
        rs1    = '0;
        rs2    = '0;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd",   rd,            32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt, res);
            check($sformatf("vec%0d_rd", i),   res,          vecs[i].exp);
            check($sformatf("vec%0d_lat", i),  lat,          vecs[i].lat);
            check($sformatf("vec%0d_busy", i), bcnt,         (vecs[i].lat == 1) ? 32'd0 : 32'd32);
        end

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            issue(f, a, b);
            wait_done(lat, bcnt, res);
            check($sformatf("rnd%0d_f%0d_rd", i, f), res, model(f, a, b));
            check($sformatf("rnd%0d_lat", i),        lat, model_lat(f, a, b));
        end

        // start during CALC is ignored and does not restart the iteration
        issue(3'd5, 32'd1000, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        funct3 = 3'd0;
        rs1    = 32'd3;
        rs2    = 32'd5;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt, res);
        check("ignore_start_rd",  res, 32'd142);
        check("ignore_start_lat", lat, 32'd28);

        // back-to-back: start in the done cycle is accepted
        issue(3'd0, 32'd7, 32'd3);
        wait_done(lat, bcnt, res);
        check("b2b_first_rd", res, 32'd21);
        issue(3'd7, 32'd100, 32'd7);
        check("b2b_rd_hold",  rd,             32'd21);
        check("b2b_busy",     {31'd0, busy},  32'd1);
        wait_done(lat, bcnt, res);
        check("b2b_second_rd",  res, 32'd2);
        check("b2b_second_lat", lat, 32'd33);

        // reset at CALC edge 10 aborts the operation
        issue(3'd0, 32'd7, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_rd",   rd,            32'd0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        bcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check("midrst_no_done", dcnt, 32'd0);
        check("midrst_no_busy", bcnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative multi-cycle multiply/divide unit implementing the RV32M operations for the riscy32 core.
- Sits beside the combinational ALU in the execute stage. The ALU covers single-cycle integer ops; this block covers MUL*/DIV*/REM*.
- The control path issues an operation with a start strobe, stalls while busy is high, and captures rd on the single-cycle done pulse.
- Uses a shift-add multiplier and a restoring divider: one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when busy=0
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  XLEN  operand A / dividend
- rs2  input  XLEN  operand B / divisor
- busy  output  1  high while an operation is iterating; combinational from state
- done  output  1  registered one-cycle pulse; rd is valid from this cycle on
- rd  output  XLEN  result register; holds its value until the next done

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, busy=0, done=0, rd=0, iteration counter=0.
  - A reset asserted mid-operation aborts the operation. No done is produced, and rd is cleared.
- States are IDLE and CALC.
  - busy = (state==CALC).
  - done defaults to 0 every cycle unless set as described below.
- IDLE, at an edge with start=1:
  - latch funct3, latch operand signs, load magnitudes, counter=XLEN-1.
  - Sign rules: MULH takes both operands signed. MULHSU takes rs1 signed and rs2 unsigned. MULHU, DIVU and REMU are unsigned. DIV and REM are signed. MUL is sign-agnostic (low half).
  - The next state is CALC, unless a fast path applies.
- Fast paths (taken at the start edge, no CALC): rd is written, done=1 next cycle, state stays IDLE.
  - rs2==0: DIV/DIVU give all-ones, REM/REMU give rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF gives 0x80000000.
  - REM with the same operands gives 0.
- CALC performs one iteration per edge.
  - Multiply: if multiplier LSB=1, add multiplicand into the upper half of a 2*XLEN accumulator, then shift right by 1.
  - Divide: shift the {remainder, quotient} pair left by 1, trial-subtract the divisor from the remainder, and keep the difference if it is non-negative (quotient bit 1).
  - The counter decrements each edge.
  - At the edge where counter==0:
    - apply the sign fix-up.
    - Product is negated if the effective signs differ.
    - Quotient is negated if the dividend and divisor signs differ.
    - Remainder takes the sign of the dividend.
    - Select the result: MUL takes the low XLEN bits, MULH/MULHSU/MULHU the high bits, DIV/DIVU the quotient, REM/REMU the remainder.
    - Write rd, set done=1, and set state=IDLE.
- Latency:
  - Normal path: done is high in the cycle after the XLEN-th CALC edge, i.e. XLEN+1 edges after the start edge (33 for XLEN=32).
  - Fast path: 1 edge.
- Back-to-back: because busy=0 in the done cycle, a start asserted in that cycle is accepted. The new operation's done follows at the normal latency.
- start while busy=1 is ignored (not queued). Changes to rs1, rs2 or funct3 during CALC have no effect because the operands are latched.
- All arithmetic is modulo 2^XLEN. Internal magnitudes are XLEN-bit unsigned; the trial subtraction is XLEN+1 bits wide.

Test Plan:
- Reset mid-operation: start MUL, assert rst at CALC edge 10 → busy=0, done=0, rd=0; no done pulse follows.
- MUL: rs1=7, rs2=0xFFFFFFFD → done exactly 33 edges after start, rd=0xFFFFFFEB; busy high for 32 cycles.
- High multiplies, each checked against a 64-bit reference model:
  - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0xFFFFFFFF*0xFFFFFFFF → 0x00000000.
  - MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF.
- Signed division:
  - DIV rs1=0xFFFFFFF9 (-7), rs2=2 → rd=0xFFFFFFFD.
  - REM with the same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases, each with done exactly 1 edge after start and busy never high:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Handshake:
  - Assert start again during CALC with different operands → ignored, original result delivered.
  - Assert start in the done cycle → accepted; second done follows 33 edges later; rd holds the first result until then.
